// File: rtl/inversion_ti_pipe.sv
// Elastic multi-lane 2-share GF(2^8) inverter (AES field, 0 -> 0). It computes x^254 with a
// three-stage chain of shared multiplications, and an optional final stage compresses 4 shares to 2.
module inversion_ti_pipe #(
  parameter int  LANES    = 4,
  parameter int  COMPRESS = 0,
  localparam int RW       = 64 + 8*COMPRESS
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*LANES-1:0]  in_s0,
  input  logic [8*LANES-1:0]  in_s1,
  input  logic [RW*LANES-1:0] rnd,
  input  logic                rnd_valid,
  output logic                rnd_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*LANES-1:0]  out_s0,
  output logic [8*LANES-1:0]  out_s1,
  output logic [8*LANES-1:0]  out_s2,
  output logic [8*LANES-1:0]  out_s3,
  output logic                busy
);
  localparam int D = 3 + COMPRESS;

  // Handshake: the whole pipe shifts only on adv. An input beat is taken and the output beat
  // retires on the same adv. Each adv uses up the current rnd word.
  logic [D-1:0] v;
  logic         adv;
  logic         step;

  assign adv       = rnd_valid && (!v[D-1] || out_ready);
  assign step      = adv && !flush;
  assign in_ready  = adv;
  assign rnd_ack   = adv;
  assign out_valid = v[D-1];
  assign busy      = |v;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)      v <= '0;
    else if (flush) v <= '0;
    else if (adv)   v <= {v[D-2:0], in_valid};
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_p4(input logic [7:0] a);
    logic [7:0] s;
    s = gf_mul(a, a);
    return gf_mul(s, s);
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RW-1:0] r;
    logic [7:0] a0, a1, sa0, sa1, n3_0, n3_1;
    logic [7:0] x3_0, x3_1, x2_0, x2_1;
    logic [7:0] q0, q1, n15_0, n15_1, n14_0, n14_1;
    logic [7:0] x15_0, x15_1, x14_0, x14_1;
    logic [7:0] e0, e1, nt0, nt1, nt2, nt3;
    logic [7:0] t0, t1, t2, t3;

    assign r   = rnd[RW*k +: RW];
    assign a0  = in_s0[8*k +: 8];
    assign a1  = in_s1[8*k +: 8];
    assign sa0 = gf_mul(a0, a0);
    assign sa1 = gf_mul(a1, a1);

    // Stage1: x^3 = x * x^2. The extra random nibble is added to both shares, so it cancels.
    assign n3_0 = (gf_mul(a0, sa0) ^ r[43:36]) ^ gf_mul(a0, sa1) ^ {4'h0, r[47:44]};
    assign n3_1 = (gf_mul(a1, sa0) ^ r[43:36]) ^ gf_mul(a1, sa1) ^ {4'h0, r[47:44]};

    // Stage2: x^15 = x^3 * x^12 and x^14 = x^12 * x^2
    assign q0    = gf_p4(x3_0);
    assign q1    = gf_p4(x3_1);
    assign n15_0 = (gf_mul(x3_0, q0) ^ r[31:24]) ^ gf_mul(x3_0, q1) ^ {4'h0, r[35:32]};
    assign n15_1 = (gf_mul(x3_1, q0) ^ r[31:24]) ^ gf_mul(x3_1, q1) ^ {4'h0, r[35:32]};
    assign n14_0 = (gf_mul(q0, x2_0) ^ r[55:48]) ^ gf_mul(q0, x2_1) ^ r[63:56];
    assign n14_1 = (gf_mul(q1, x2_0) ^ r[55:48]) ^ gf_mul(q1, x2_1) ^ r[63:56];

    // Stage3: x^254 = (x^15)^16 * x^14. The four cross products get a zero-sum refresh.
    assign e0  = gf_p4(gf_p4(x15_0));
    assign e1  = gf_p4(gf_p4(x15_1));
    assign nt0 = gf_mul(e0, x14_0) ^ r[7:0];
    assign nt1 = gf_mul(e0, x14_1) ^ r[15:8];
    assign nt2 = gf_mul(e1, x14_0) ^ r[23:16];
    assign nt3 = gf_mul(e1, x14_1) ^ r[7:0] ^ r[15:8] ^ r[23:16];

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        {x3_0, x3_1, x2_0, x2_1}     <= '0;
        {x15_0, x15_1, x14_0, x14_1} <= '0;
        {t0, t1, t2, t3}             <= '0;
      end else if (step) begin
        {x3_0, x3_1, x2_0, x2_1}     <= {n3_0, n3_1, sa0, sa1};
        {x15_0, x15_1, x14_0, x14_1} <= {n15_0, n15_1, n14_0, n14_1};
        {t0, t1, t2, t3}             <= {nt0, nt1, nt2, nt3};
      end
    end

    if (COMPRESS != 0) begin : g_cmp
      logic [7:0] rc, c0, c1;
      assign rc = r[64 +: 8];
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          c0 <= 8'h00;
          c1 <= 8'h00;
        end else if (step) begin
          c0 <= t0 ^ t1 ^ rc;
          c1 <= t2 ^ t3 ^ rc;
        end
      end
      assign out_s0[8*k +: 8] = c0;
      assign out_s1[8*k +: 8] = c1;
      assign out_s2[8*k +: 8] = 8'h00;
      assign out_s3[8*k +: 8] = 8'h00;
    end else begin : g_raw
      assign out_s0[8*k +: 8] = t0;
      assign out_s1[8*k +: 8] = t1;
      assign out_s2[8*k +: 8] = t2;
      assign out_s3[8*k +: 8] = t3;
    end
  end
endmodule

// File: tb/tb_inversion_ti_pipe.sv
// Bench for inversion_ti_pipe: one 4-share and one compressed instance are driven from shared stimulus.
// A scoreboard compares each retired beat with a brute-force GF(2^8) inverse.
module tb_inversion_ti_pipe;
  localparam int LANES = 4;
  localparam int W     = 8*LANES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, rnd_valid, out_ready;
  logic [W-1:0] in_s0, in_s1;
  logic [64*LANES-1:0] rnd0;
  logic [72*LANES-1:0] rnd1;
  logic in_ready0, rnd_ack0, out_valid0, busy0;
  logic in_ready1, rnd_ack1, out_valid1, busy1;
  logic [W-1:0] o0_s0, o0_s1, o0_s2, o0_s3, o1_s0, o1_s1, o1_s2, o1_s3;

  inversion_ti_pipe #(.LANES(LANES), .COMPRESS(0)) dut0 (
    .CLK(clk), .RSTn(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_s0(in_s0), .in_s1(in_s1), .rnd(rnd0), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_s0(o0_s0), .out_s1(o0_s1),
    .out_s2(o0_s2), .out_s3(o0_s3), .busy(busy0));

  inversion_ti_pipe #(.LANES(LANES), .COMPRESS(1)) dut1 (
    .CLK(clk), .RSTn(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_s0(in_s0), .in_s1(in_s1), .rnd(rnd1), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_s0(o1_s0), .out_s1(o1_s1),
    .out_s2(o1_s2), .out_s3(o1_s3), .busy(busy1));

  // Selected instance view
  logic sel;
  logic in_ready_m, rnd_ack_m, out_valid_m, busy_m;
  logic [W-1:0] s0_m, s1_m, s2_m, s3_m, xor_m;
  always_comb begin
    in_ready_m  = sel ? in_ready1  : in_ready0;
    rnd_ack_m   = sel ? rnd_ack1   : rnd_ack0;
    out_valid_m = sel ? out_valid1 : out_valid0;
    busy_m      = sel ? busy1      : busy0;
    s0_m        = sel ? o1_s0 : o0_s0;
    s1_m        = sel ? o1_s1 : o0_s1;
    s2_m        = sel ? o1_s2 : o0_s2;
    s3_m        = sel ? o1_s3 : o0_s3;
    xor_m       = sel ? (o1_s0 ^ o1_s1) : (o0_s0 ^ o0_s1 ^ o0_s2 ^ o0_s3);
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  logic [W-1:0] cur_exp;
  int checks = 0, errors = 0, cycle = 0;
  logic chk_lat = 1'b0, held = 1'b0, last_acc = 1'b0;
  logic [4*W-1:0] held_val;

  typedef struct { logic [7:0] x; logic [7:0] inv; } vec_t;
  vec_t tv[10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, act, exp);
    end
  endtask

  task automatic rand_rnd();
    for (int i = 0; i < 8*LANES; i++) rnd0[8*i +: 8] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9*LANES; i++) rnd1[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  // One cycle: sample 1ns after the negedge, then wait for the next negedge
  task automatic tick();
    logic [W-1:0] e;
    int c;
    rand_rnd();
    #1;
    last_acc = in_valid && in_ready_m;
    if (last_acc) begin
      exp_q.push_back(cur_exp);
      cyc_q.push_back(cycle);
    end
    if (held && out_valid_m) check("hold_stable", {s0_m, s1_m, s2_m, s3_m}, held_val);
    if (out_valid_m && out_ready && rnd_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {96'd0, xor_m}, '0);
        if (xor_m == '0) begin
          errors++;
          $display("FAIL spurious_out cycle=%0d actual=valid expected=no beat", cycle);
        end
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("data", {96'd0, xor_m}, {96'd0, e});
        if (chk_lat) check("latency", 128'(cycle - c), sel ? 128'd4 : 128'd3);
        if (sel) check("s2_s3_zero", {64'd0, s2_m, s3_m}, '0);
      end
    end
    held     = out_valid_m && !(out_ready && rnd_valid);
    held_val = {s0_m, s1_m, s2_m, s3_m};
    @(negedge clk);
    cycle++;
  endtask

  task automatic set_beat(input logic [W-1:0] x, input logic [W-1:0] e);
    logic [W-1:0] m;
    for (int i = 0; i < LANES; i++) m[8*i +: 8] = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    in_s0    = m;
    in_s1    = x ^ m;
    cur_exp  = e;
  endtask

  task automatic wait_acc();
    int n = 0;
    tick();
    while (!last_acc && n < 50) begin
      tick();
      n++;
    end
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cycle=%0d actual=no accept expected=accept", cycle);
    end
  endtask

  task automatic send(input logic [W-1:0] x);
    logic [W-1:0] e;
    for (int i = 0; i < LANES; i++) e[8*i +: 8] = ginv(x[8*i +: 8]);
    set_beat(x, e);
    wait_acc();
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cycle=%0d actual=%0d pending expected=0", cycle, exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic random_word(output logic [W-1:0] x);
    for (int i = 0; i < LANES; i++) x[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  task automatic stream_all();
    logic [W-1:0] x;
    chk_lat = 1'b1;
    for (int b = 0; b < 256; b++) begin
      for (int k = 0; k < LANES; k++) x[8*k +: 8] = 8'(b + 64*k);
      send(x);
    end
    drain();
    chk_lat = 1'b0;
  endtask

  task automatic run_table();
    logic [W-1:0] x, e;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < LANES; k++) begin
        x[8*k +: 8] = tv[(i + k) % 10].x;
        e[8*k +: 8] = tv[(i + k) % 10].inv;
      end
      set_beat(x, e);
      wait_acc();
    end
    drain();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    held  = 1'b0;
    exp_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    logic [W-1:0] x;
    tv[0] = '{8'h00, 8'h00}; tv[1] = '{8'h01, 8'h01}; tv[2] = '{8'h02, 8'h8d};
    tv[3] = '{8'h03, 8'hf6}; tv[4] = '{8'h53, 8'hca}; tv[5] = '{8'hca, 8'h53};
    tv[6] = '{8'h8d, 8'h02}; tv[7] = '{8'hf6, 8'h03}; tv[8] = '{8'hff, 8'h1c};
    tv[9] = '{8'h1c, 8'hff};

    sel = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
    out_ready = 1'b0; in_s0 = '0; in_s1 = '0; cur_exp = '0; rand_rnd();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid0}, '0);
    check("rst_busy", {127'd0, busy0}, '0);
    check("rst_outputs", {o0_s0, o0_s1, o0_s2, o0_s3}, '0);
    check("rst_in_ready", {126'd0, in_ready0, rnd_ack0}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors and the full streaming sweep
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    run_table();
    stream_all();

    // Backpressure with a full pipe
    for (int i = 0; i < 3; i++) begin random_word(x); send(x); end
    out_ready = 1'b0;
    random_word(x);
    send_prep: begin
      logic [W-1:0] e;
      for (int i = 0; i < LANES; i++) e[8*i +: 8] = ginv(x[8*i +: 8]);
      set_beat(x, e);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", {127'd0, in_ready_m}, '0);
      check("bp_out_valid", {127'd0, out_valid_m}, 128'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_acc();
    drain();

    // Randomness starvation mid-stream
    for (int i = 0; i < 4; i++) begin random_word(x); send(x); end
    random_word(x);
    for (int i = 0; i < LANES; i++) cur_exp[8*i +: 8] = ginv(x[8*i +: 8]);
    set_beat(x, cur_exp);
    rnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("starve_ack", {126'd0, rnd_ack_m, in_ready_m}, '0);
      tick();
    end
    rnd_valid = 1'b1;
    wait_acc();
    for (int i = 0; i < 3; i++) begin random_word(x); send(x); end
    drain();

    // Flush with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin random_word(x); send(x); end
    in_valid = 1'b0;
    #1;
    check("pre_flush_busy", {127'd0, busy_m}, 128'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", {126'd0, busy_m, out_valid_m}, '0);
    exp_q.delete();
    cyc_q.delete();
    out_ready = 1'b1;
    random_word(x);
    send(x);
    drain();
    for (int i = 0; i < 5; i++) tick();

    // Asynchronous reset mid-stream with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin random_word(x); send(x); end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {126'd0, out_valid_m, busy_m}, '0);
    check("async_rst_data", {o0_s0, o0_s1, o0_s2, o0_s3}, '0);
    exp_q.delete();
    cyc_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_idle", {127'd0, out_valid_m}, '0);

    // Compressed instance
    sel = 1'b1;
    pulse_reset();
    stream_all();
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
